ozphy_ltssm_array: RTL and testbench
====================================

# ozphy_ltssm_array

Parametrised per-lane PIPE-side LTSSM engine for the ozphy PHY model. It replaces the fixed 16-lane detect/polling logic with N_LANES independent lane FSMs. Each FSM runs receiver detect, Polling.Active TS1 transmission, Polling.Configuration TS2 exchange and entry to L0. The block sits between the PIPE control signals and the 8b/10b encoders/decoders: it drives the TS symbol stream into the encoders and consumes ordered-set detect pulses from the decoders.

## Interface
- N_LANES, 16: number of lanes (1..32)
- NTS, 1024: TS1s each lane must send in Polling.Active before it may advance
- DETECT_WAIT, 8: cycles spent in DETECT_ACTIVE before powerdown is sampled
- RX_TS_REQ, 8: consecutive received TS1/TS2 required to advance
- TX_TS2_REQ, 16: TS2s each lane must send in Polling.Configuration
- clk  in  1  PIPE clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- txdetectrx  in  N_LANES  receiver-detect request per lane
- powerdown  in  3*N_LANES  per-lane PIPE powerdown; lane i uses bits [3i+2:3i]
- rx_ts1_seen  in  N_LANES  1-cycle pulse: decoder recognised a complete TS1
- rx_ts2_seen  in  N_LANES  1-cycle pulse: decoder recognised a complete TS2
- rx_os_bad  in  N_LANES  1-cycle pulse: malformed ordered set; clears the RX count
- rxstatus  out  3*N_LANES  PIPE rxstatus per lane
- phystatus  out  N_LANES  PIPE phystatus, 1-cycle pulses
- rxelecidle  out  N_LANES  receiver electrical idle
- tx_sym  out  8*N_LANES  TS symbol to the encoder
- tx_symk  out  N_LANES  K flag for tx_sym
- tx_valid  out  N_LANES  tx_sym is meaningful
- lane_state  out  3*N_LANES  encoded LTSSM_State per lane
- linkup  out  N_LANES  lane is in L0

## Operation
- Reset values: state DETECT_QUIET, rxstatus 0, phystatus 0, rxelecidle 1, tx_sym 0, tx_symk 0, tx_valid 0, linkup 0, all counters 0.
- Lanes are fully independent; no cross-lane coupling.
- **DETECT_QUIET**: rxstatus=0. On txdetectrx=1: rxstatus=3'b011, phystatus pulses, go to DETECT_ACTIVE.
- **DETECT_ACTIVE**:
  - rxstatus returns to 0 after one cycle; wait counter runs DETECT_WAIT cycles.
  - Then, if powerdown==0: phystatus pulses, rxelecidle=0, go to POLLING_ACTIVE.
  - If powerdown==2: go to DETECT_QUIET.
  - Otherwise hold.
- **POLLING_ACTIVE**:
  - Transmit TS1 continuously with tx_valid=1. 16 symbols per set, index 0..15:
    - 0: 0xBC K
    - 1, 2: 0xF7 K (PAD)
    - 3: 0x00 (N_FTS)
    - 4: 0x02 (rate)
    - 5: 0x00 (training control)
    - 6..15: 0x4A
  - tx_ts_cnt increments at symbol 15 and saturates at NTS.
  - rx_ts_cnt increments on rx_ts1_seen or rx_ts2_seen, saturates at RX_TS_REQ, and clears on rx_os_bad.
  - At symbol 15, if tx_ts_cnt will reach NTS and rx_ts_cnt==RX_TS_REQ: go to POLLING_CONFIG and clear both counters.
- **POLLING_CONFIG**:
  - Transmit TS2 (symbols 6..15 = 0x45).
  - rx_ts_cnt counts rx_ts2_seen only; rx_ts1_seen or rx_os_bad clears it.
  - At symbol 15, if tx_ts_cnt reaches TX_TS2_REQ and rx_ts_cnt==RX_TS_REQ: go to L0 and set linkup=1.
- **L0**:
  - tx_valid=0, tx_sym=0.
  - powerdown==2 → DETECT_QUIET: linkup=0, rxelecidle=1.
- From POLLING_ACTIVE or POLLING_CONFIG, powerdown==2 aborts to DETECT_QUIET at the next edge, mid-set; the symbol index resets.
- Simultaneous increment and clear on rx_ts_cnt: clear wins.

## Timing
- All outputs are registered; one cycle from input sample to output.
- phystatus is exactly one cycle wide per event.
- The symbol index advances every cycle while tx_valid=1 and wraps from 15 to 0.
- A state change from POLLING_ACTIVE to POLLING_CONFIG takes effect on the first symbol of the next set, so no TS set is truncated.
- Counter widths: $clog2(NTS+1) and $clog2(RX_TS_REQ+1).
- Reset asserted mid-operation returns every lane to reset values on the next edge.

## Structure
- ozphy_pkg holds:
  - LTSSM_State enum, extended with POLLING_CONFIG and L0, 3-bit encoding
  - COM, PAD, TS1_ID, TS2_ID and RATE_GEN1 constants
- Sub-module ozphy_lane_ltssm holds one lane FSM, the TS generator and the counters. The top generates N_LANES instances and does the vector slicing.

## Test plan
- N_LANES=4, NTS=4: pulse txdetectrx on lane 2 → next cycle rxstatus[8:6]=3'b011, phystatus[2]=1; other lanes remain in DETECT_QUIET.
- Hold powerdown=2 through DETECT_WAIT → lane returns to DETECT_QUIET. Repeat with powerdown=0 → phystatus pulse, rxelecidle=0, POLLING_ACTIVE.
- In POLLING_ACTIVE, check the tx_sym sequence: BC/K, F7/K, F7/K, 00, 02, 00, then ten 4A; the sequence repeats with period 16.
- Feed 8 rx_ts1_seen pulses, inject rx_os_bad after 5, then send 8 more → advance occurs only after 4 TS1 sent and 8 clean RX sets, exactly at a set boundary; TS2 symbols show 0x45.
- Complete 16 TS2 sent and 8 rx_ts2_seen → linkup=1, tx_valid=0. Then powerdown=2 → linkup=0, rxelecidle=1, DETECT_QUIET.
- Assert reset in POLLING_CONFIG mid-set → all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/ozphy_pkg.sv
// ozphy LTSSM shared types and training-set constants.
// Symbol values and state encoding used by every lane engine.
package ozphy_pkg;

    typedef enum logic [2:0] {
        DETECT_QUIET   = 3'd0,
        DETECT_ACTIVE  = 3'd1,
        POLLING_ACTIVE = 3'd2,
        POLLING_CONFIG = 3'd3,
        L0             = 3'd4
    } LTSSM_State;

    localparam logic [7:0] COM       = 8'hBC;
    localparam logic [7:0] PAD       = 8'hF7;
    localparam logic [7:0] TS1_ID    = 8'h4A;
    localparam logic [7:0] TS2_ID    = 8'h45;
    localparam logic [7:0] RATE_GEN1 = 8'h02;
    localparam logic [7:0] NFTS_VAL  = 8'h00;
    localparam logic [7:0] TRAIN_CTL = 8'h00;

    localparam logic [2:0] PD_P0      = 3'd0;
    localparam logic [2:0] PD_P2      = 3'd2;
    localparam logic [2:0] RXSTAT_DET = 3'b011;

    // {K flag, byte} for position idx of a TS1 or TS2 set
    function automatic logic [8:0] ts_sym(input logic [3:0] idx,
                                          input logic is_ts2);
        logic [8:0] s;
        case (idx)
            4'd0:       s = {1'b1, COM};
            4'd1, 4'd2: s = {1'b1, PAD};
            4'd3:       s = {1'b0, NFTS_VAL};
            4'd4:       s = {1'b0, RATE_GEN1};
            4'd5:       s = {1'b0, TRAIN_CTL};
            default:    s = {1'b0, is_ts2 ? TS2_ID : TS1_ID};
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ozphy_lane_ltssm.sv
// Single-lane LTSSM: detect, polling TS1/TS2 exchange, L0.
// All PIPE and symbol outputs are registered from next state.
module ozphy_lane_ltssm
    import ozphy_pkg::*;
#(
    parameter int NTS         = 1024,
    parameter int DETECT_WAIT = 8,
    parameter int RX_TS_REQ   = 8,
    parameter int TX_TS2_REQ  = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       txdetectrx_i,
    input  logic [2:0] powerdown_i,
    input  logic       rx_ts1_seen_i,
    input  logic       rx_ts2_seen_i,
    input  logic       rx_os_bad_i,
    output logic [2:0] rxstatus_o,
    output logic       phystatus_o,
    output logic       rxelecidle_o,
    output logic [7:0] tx_sym_o,
    output logic       tx_symk_o,
    output logic       tx_valid_o,
    output logic [2:0] state_o,
    output logic       linkup_o
);

    localparam int TXMAX = (NTS > TX_TS2_REQ) ? NTS : TX_TS2_REQ;
    localparam int TXW   = $clog2(TXMAX + 1);
    localparam int RXW   = $clog2(RX_TS_REQ + 1);
    localparam int WW    = $clog2(DETECT_WAIT + 1);

    localparam logic [TXW:0]   TS1_GOAL = (TXW + 1)'(NTS);
    localparam logic [TXW:0]   TS2_GOAL = (TXW + 1)'(TX_TS2_REQ);
    localparam logic [TXW:0]   TX_ONE   = (TXW + 1)'(1);
    localparam logic [RXW-1:0] RX_FULL  = RXW'(RX_TS_REQ);
    localparam logic [RXW-1:0] RX_ONE   = RXW'(1);
    localparam logic [WW-1:0]  WAIT_END = WW'(DETECT_WAIT);
    localparam logic [WW-1:0]  WAIT_ONE = WW'(1);

    LTSSM_State     state_q, state_d;
    logic [WW-1:0]  wait_q, wait_d;
    logic [3:0]     idx_q, idx_d;
    logic [TXW-1:0] txc_q, txc_d;
    logic [RXW-1:0] rxc_q, rxc_d;
    logic [2:0]     rxs_q, rxs_d;
    logic           phy_q, phy_d;
    logic           ei_q, ei_d;
    logic           link_q, link_d;
    logic [7:0]     sym_q, sym_d;
    logic           symk_q, symk_d;
    logic           valid_q, valid_d;

    logic           in_cfg, abort, set_end, rx_full;
    logic           rx_clr, rx_hit, advance;
    logic [TXW:0]   tx_goal, tx_inc;
    logic [TXW-1:0] tx_sat;
    logic [RXW-1:0] rx_next;

    // Counter arithmetic and set-boundary advance decision
    always_comb begin
        in_cfg  = (state_q == POLLING_CONFIG);
        abort   = (powerdown_i == PD_P2);
        set_end = (idx_q == 4'd15);
        rx_full = (rxc_q == RX_FULL);
        rx_clr  = rx_os_bad_i | (in_cfg & rx_ts1_seen_i);
        rx_hit  = rx_ts2_seen_i | (~in_cfg & rx_ts1_seen_i);
        tx_goal = in_cfg ? TS2_GOAL : TS1_GOAL;
        tx_inc  = {1'b0, txc_q} + TX_ONE;
        tx_sat  = (tx_inc >= tx_goal) ? tx_goal[TXW-1:0]
                                      : tx_inc[TXW-1:0];
        advance = set_end & (tx_inc >= tx_goal) & rx_full;
        if (rx_clr)
            rx_next = '0;
        else if (rx_hit && !rx_full)
            rx_next = rxc_q + RX_ONE;
        else
            rx_next = rxc_q;
    end

    // Lane state transitions and per-event PIPE status
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        idx_d   = idx_q;
        txc_d   = txc_q;
        rxc_d   = rxc_q;
        rxs_d   = 3'd0;
        phy_d   = 1'b0;
        ei_d    = ei_q;
        link_d  = link_q;
        unique case (state_q)
            DETECT_QUIET: begin
                if (txdetectrx_i) begin
                    state_d = DETECT_ACTIVE;
                    wait_d  = '0;
                    rxs_d   = RXSTAT_DET;
                    phy_d   = 1'b1;
                end
            end
            DETECT_ACTIVE: begin
                if (wait_q != WAIT_END) begin
                    wait_d = wait_q + WAIT_ONE;
                end else if (powerdown_i == PD_P0) begin
                    state_d = POLLING_ACTIVE;
                    idx_d   = '0;
                    txc_d   = '0;
                    rxc_d   = '0;
                    phy_d   = 1'b1;
                    ei_d    = 1'b0;
                end else if (abort) begin
                    state_d = DETECT_QUIET;
                end
            end
            POLLING_ACTIVE, POLLING_CONFIG: begin
                if (abort) begin
                    state_d = DETECT_QUIET;
                    idx_d   = '0;
                    txc_d   = '0;
                    rxc_d   = '0;
                    ei_d    = 1'b1;
                end else begin
                    idx_d = idx_q + 4'd1;
                    rxc_d = rx_next;
                    if (set_end)
                        txc_d = tx_sat;
                    if (advance) begin
                        txc_d = '0;
                        rxc_d = '0;
                        if (in_cfg) begin
                            state_d = L0;
                            link_d  = 1'b1;
                        end else begin
                            state_d = POLLING_CONFIG;
                        end
                    end
                end
            end
            L0: begin
                if (abort) begin
                    state_d = DETECT_QUIET;
                    link_d  = 1'b0;
                    ei_d    = 1'b1;
                end
            end
            default: state_d = DETECT_QUIET;
        endcase
    end

    // TS symbol for the set position about to be driven
    always_comb begin
        valid_d = (state_d == POLLING_ACTIVE) ||
                  (state_d == POLLING_CONFIG);
        if (valid_d)
            {symk_d, sym_d} = ts_sym(idx_d, state_d == POLLING_CONFIG);
        else
            {symk_d, sym_d} = 9'd0;
    end

    // State, counter and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= DETECT_QUIET;
            wait_q  <= '0;
            idx_q   <= '0;
            txc_q   <= '0;
            rxc_q   <= '0;
            rxs_q   <= '0;
            phy_q   <= 1'b0;
            ei_q    <= 1'b1;
            link_q  <= 1'b0;
            sym_q   <= '0;
            symk_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            idx_q   <= idx_d;
            txc_q   <= txc_d;
            rxc_q   <= rxc_d;
            rxs_q   <= rxs_d;
            phy_q   <= phy_d;
            ei_q    <= ei_d;
            link_q  <= link_d;
            sym_q   <= sym_d;
            symk_q  <= symk_d;
            valid_q <= valid_d;
        end
    end

    assign rxstatus_o   = rxs_q;
    assign phystatus_o  = phy_q;
    assign rxelecidle_o = ei_q;
    assign tx_sym_o     = sym_q;
    assign tx_symk_o    = symk_q;
    assign tx_valid_o   = valid_q;
    assign state_o      = state_q;
    assign linkup_o     = link_q;

endmodule

// File: rtl/ozphy_ltssm_array.sv
// Array of N_LANES independent lane LTSSM engines.
// Only slices the flat PIPE vectors; lanes never interact.
module ozphy_ltssm_array
    import ozphy_pkg::*;
#(
    parameter int N_LANES     = 16,
    parameter int NTS         = 1024,
    parameter int DETECT_WAIT = 8,
    parameter int RX_TS_REQ   = 8,
    parameter int TX_TS2_REQ  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_LANES-1:0]     txdetectrx,
    input  logic [3*N_LANES-1:0]   powerdown,
    input  logic [N_LANES-1:0]     rx_ts1_seen,
    input  logic [N_LANES-1:0]     rx_ts2_seen,
    input  logic [N_LANES-1:0]     rx_os_bad,
    output logic [3*N_LANES-1:0]   rxstatus,
    output logic [N_LANES-1:0]     phystatus,
    output logic [N_LANES-1:0]     rxelecidle,
    output logic [8*N_LANES-1:0]   tx_sym,
    output logic [N_LANES-1:0]     tx_symk,
    output logic [N_LANES-1:0]     tx_valid,
    output logic [3*N_LANES-1:0]   lane_state,
    output logic [N_LANES-1:0]     linkup
);

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        ozphy_lane_ltssm #(
            .NTS         (NTS),
            .DETECT_WAIT (DETECT_WAIT),
            .RX_TS_REQ   (RX_TS_REQ),
            .TX_TS2_REQ  (TX_TS2_REQ)
        ) u_lane (
            .clk_i         (clk),
            .rst_i         (reset),
            .txdetectrx_i  (txdetectrx[i]),
            .powerdown_i   (powerdown[3*i +: 3]),
            .rx_ts1_seen_i (rx_ts1_seen[i]),
            .rx_ts2_seen_i (rx_ts2_seen[i]),
            .rx_os_bad_i   (rx_os_bad[i]),
            .rxstatus_o    (rxstatus[3*i +: 3]),
            .phystatus_o   (phystatus[i]),
            .rxelecidle_o  (rxelecidle[i]),
            .tx_sym_o      (tx_sym[8*i +: 8]),
            .tx_symk_o     (tx_symk[i]),
            .tx_valid_o    (tx_valid[i]),
            .state_o       (lane_state[3*i +: 3]),
            .linkup_o      (linkup[i])
        );
    end

endmodule

// File: tb/tb_ozphy_ltssm_array.sv
// Bench for ozphy_ltssm_array: directed bring-up plus random traffic
// compared every cycle against a per-lane behavioural model.
module tb_ozphy_ltssm_array;
    import ozphy_pkg::*;

    localparam int NL    = 4;
    localparam int NTS_P = 4;
    localparam int DW    = 8;
    localparam int RXR   = 8;
    localparam int TX2   = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [NL-1:0]     txdetectrx, rx_ts1_seen, rx_ts2_seen, rx_os_bad;
    logic [3*NL-1:0]   powerdown;
    logic [3*NL-1:0]   rxstatus, lane_state;
    logic [NL-1:0]     phystatus, rxelecidle, tx_symk, tx_valid, linkup;
    logic [8*NL-1:0]   tx_sym;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ozphy_ltssm_array #(
        .N_LANES(NL), .NTS(NTS_P), .DETECT_WAIT(DW),
        .RX_TS_REQ(RXR), .TX_TS2_REQ(TX2)
    ) dut (
        .clk(clk), .reset(reset), .txdetectrx(txdetectrx),
        .powerdown(powerdown), .rx_ts1_seen(rx_ts1_seen),
        .rx_ts2_seen(rx_ts2_seen), .rx_os_bad(rx_os_bad),
        .rxstatus(rxstatus), .phystatus(phystatus),
        .rxelecidle(rxelecidle), .tx_sym(tx_sym), .tx_symk(tx_symk),
        .tx_valid(tx_valid), .lane_state(lane_state), .linkup(linkup)
    );

    // reference model
    LTSSM_State m_st[NL];
    int  m_wait[NL], m_idx[NL], m_txc[NL], m_rxc[NL], m_rxs[NL];
    bit  m_phy[NL], m_ei[NL], m_link[NL];
    logic [7:0] hdr [6] = '{8'hBC, 8'hF7, 8'hF7, 8'h00, 8'h02, 8'h00};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    function automatic bit m_polling(int l);
        return m_st[l] == POLLING_ACTIVE || m_st[l] == POLLING_CONFIG;
    endfunction

    function automatic logic [7:0] m_sym(int l);
        if (!m_polling(l)) return 8'h00;
        if (m_idx[l] < 6) return hdr[m_idx[l]];
        return (m_st[l] == POLLING_CONFIG) ? 8'h45 : 8'h4A;
    endfunction

    task automatic m_reset();
        for (int l = 0; l < NL; l++) begin
            m_st[l] = DETECT_QUIET;
            m_wait[l] = 0; m_idx[l] = 0; m_txc[l] = 0;
            m_rxc[l] = 0;  m_rxs[l] = 0;
            m_phy[l] = 0;  m_ei[l] = 1; m_link[l] = 0;
        end
    endtask

    task automatic m_step();
        int pdv, goal;
        bit cfg, full;
        if (reset) begin
            m_reset();
            return;
        end
        for (int l = 0; l < NL; l++) begin
            pdv = int'(powerdown[3*l +: 3]);
            m_phy[l] = 0;
            m_rxs[l] = 0;
            case (m_st[l])
                DETECT_QUIET:
                    if (txdetectrx[l]) begin
                        m_rxs[l] = 3; m_phy[l] = 1;
                        m_st[l] = DETECT_ACTIVE; m_wait[l] = 0;
                    end
                DETECT_ACTIVE:
                    if (m_wait[l] < DW) m_wait[l]++;
                    else if (pdv == 0) begin
                        m_phy[l] = 1; m_ei[l] = 0;
                        m_st[l] = POLLING_ACTIVE;
                        m_idx[l] = 0; m_txc[l] = 0; m_rxc[l] = 0;
                    end else if (pdv == 2) m_st[l] = DETECT_QUIET;
                POLLING_ACTIVE, POLLING_CONFIG:
                    if (pdv == 2) begin
                        m_st[l] = DETECT_QUIET; m_ei[l] = 1;
                        m_idx[l] = 0; m_txc[l] = 0; m_rxc[l] = 0;
                    end else begin
                        cfg  = (m_st[l] == POLLING_CONFIG);
                        full = (m_rxc[l] == RXR);
                        if (rx_os_bad[l] || (cfg && rx_ts1_seen[l]))
                            m_rxc[l] = 0;
                        else if (rx_ts2_seen[l] || (!cfg && rx_ts1_seen[l]))
                            m_rxc[l] = (m_rxc[l] < RXR) ? m_rxc[l] + 1 : RXR;
                        if (m_idx[l] == 15) begin
                            goal = cfg ? TX2 : NTS_P;
                            if (m_txc[l] + 1 < goal) m_txc[l]++;
                            else begin
                                m_txc[l] = goal;
                                if (full) begin
                                    m_txc[l] = 0; m_rxc[l] = 0;
                                    if (cfg) begin
                                        m_st[l] = L0; m_link[l] = 1;
                                    end else m_st[l] = POLLING_CONFIG;
                                end
                            end
                        end
                        m_idx[l] = (m_idx[l] + 1) % 16;
                    end
                L0:
                    if (pdv == 2) begin
                        m_st[l] = DETECT_QUIET; m_link[l] = 0; m_ei[l] = 1;
                    end
                default: ;
            endcase
        end
    endtask

    task automatic compare_all();
        logic [31:0] got, exp;
        for (int l = 0; l < NL; l++) begin
            exp = {13'd0, 3'(m_st[l]), 3'(m_rxs[l]), m_phy[l], m_ei[l],
                   m_sym(l), 1'(m_polling(l) && m_idx[l] < 3),
                   1'(m_polling(l)), m_link[l]};
            got = {13'd0, lane_state[3*l +: 3], rxstatus[3*l +: 3],
                   phystatus[l], rxelecidle[l], tx_sym[8*l +: 8],
                   tx_symk[l], tx_valid[l], linkup[l]};
            chk($sformatf("lane%0d", l), got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
        compare_all();
    endtask

    task automatic clear_in();
        txdetectrx = '0; rx_ts1_seen = '0; rx_ts2_seen = '0;
        rx_os_bad = '0;  powerdown = '0;
    endtask

    function automatic LTSSM_State dstate(int l);
        return LTSSM_State'(lane_state[3*l +: 3]);
    endfunction

    initial begin
        int npulse;
        bit bad_done;
        logic [7:0] es;
        clear_in();
        reset = 1'b1;
        tick(); tick();
        chk("rst_elecidle", 32'(rxelecidle), 32'hF);
        chk("rst_txvalid", 32'(tx_valid), 32'h0);
        reset = 1'b0;
        tick();

        // detect on lane 2 only
        txdetectrx[2] = 1'b1;
        tick();
        txdetectrx = '0;
        chk("det_rxstatus", 32'(rxstatus[8:6]), 32'h3);
        chk("det_phystatus", 32'(phystatus), 32'h4);
        chk("det_others", 32'({lane_state[11:9], lane_state[5:0]}), 32'h0);

        // powerdown P2 through the wait returns to quiet
        powerdown[8:6] = 3'd2;
        repeat (DW + 3) tick();
        chk("pd2_quiet", 32'(dstate(2)), 32'(DETECT_QUIET));
        powerdown = '0;

        txdetectrx[2] = 1'b1;
        tick();
        txdetectrx = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dstate(2) == POLLING_ACTIVE) break;
        end
        chk("enter_pa", 32'(dstate(2)), 32'(POLLING_ACTIVE));
        chk("pa_phystatus", 32'(phystatus[2]), 32'h1);
        chk("pa_elecidle", 32'(rxelecidle[2]), 32'h0);
        chk("ts1_sym0", 32'({tx_symk[2], tx_sym[23:16]}), 32'h1BC);

        // two full TS1 sets, period 16
        for (int i = 1; i < 32; i++) begin
            tick();
            es = ((i % 16) < 6) ? hdr[i % 16] : 8'h4A;
            chk("ts1_seq", 32'({tx_symk[2], tx_sym[23:16]}),
                32'({((i % 16) < 3), es}));
        end

        // 5 TS1, a bad set, then clean TS1s until config
        npulse = 0;
        bad_done = 0;
        for (int k = 0; k < 400; k++) begin
            rx_ts1_seen = '0;
            rx_os_bad = '0;
            if (k % 4 == 0) begin
                if (npulse == 5 && !bad_done) begin
                    rx_os_bad[2] = 1'b1; bad_done = 1;
                end else begin
                    rx_ts1_seen[2] = 1'b1; npulse++;
                end
            end
            tick();
            if (dstate(2) == POLLING_CONFIG) break;
        end
        clear_in();
        chk("enter_pc", 32'(dstate(2)), 32'(POLLING_CONFIG));
        chk("pc_set_start", 32'({tx_symk[2], tx_sym[23:16]}), 32'h1BC);
        repeat (6) tick();
        chk("ts2_id", 32'(tx_sym[23:16]), 32'h45);

        for (int k = 0; k < 800; k++) begin
            rx_ts2_seen[2] = (k % 4 == 0);
            tick();
            if (dstate(2) == L0) break;
        end
        clear_in();
        chk("linkup", 32'(linkup[2]), 32'h1);
        chk("l0_txvalid", 32'(tx_valid[2]), 32'h0);

        powerdown[8:6] = 3'd2;
        tick();
        powerdown = '0;
        chk("l0_exit_link", 32'(linkup[2]), 32'h0);
        chk("l0_exit_idle", 32'(rxelecidle[2]), 32'h1);
        chk("l0_exit_state", 32'(dstate(2)), 32'(DETECT_QUIET));

        // randomized traffic, all lanes
        for (int c = 0; c < 4000; c++) begin
            int r;
            reset = ($urandom_range(0, 2999) == 0);
            for (int l = 0; l < NL; l++) begin
                txdetectrx[l] = ($urandom_range(0, 19) == 0);
                r = $urandom_range(0, 1999);
                powerdown[3*l +: 3] = (r == 0) ? 3'd2 :
                    (r < 6) ? 3'($urandom_range(1, 7)) : 3'd0;
                if (m_st[l] == POLLING_ACTIVE) begin
                    rx_ts1_seen[l] = ($urandom_range(0, 3) == 0);
                    rx_ts2_seen[l] = ($urandom_range(0, 15) == 0);
                    rx_os_bad[l]   = ($urandom_range(0, 299) == 0);
                end else if (m_st[l] == POLLING_CONFIG) begin
                    rx_ts1_seen[l] = ($urandom_range(0, 399) == 0);
                    rx_ts2_seen[l] = ($urandom_range(0, 3) == 0);
                    rx_os_bad[l]   = ($urandom_range(0, 399) == 0);
                end else begin
                    rx_ts1_seen[l] = ($urandom_range(0, 31) == 0);
                    rx_ts2_seen[l] = ($urandom_range(0, 31) == 0);
                    rx_os_bad[l]   = ($urandom_range(0, 31) == 0);
                end
            end
            tick();
        end

        // reset asserted mid-set in polling config
        clear_in();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        txdetectrx = '1;
        tick();
        txdetectrx = '0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (dstate(0) == POLLING_ACTIVE) break;
        end
        for (int k = 0; k < 400; k++) begin
            rx_ts1_seen = (k % 3 == 0) ? '1 : '0;
            tick();
            if (dstate(0) == POLLING_CONFIG) break;
        end
        rx_ts1_seen = '0;
        chk("mid_pc", 32'(dstate(0)), 32'(POLLING_CONFIG));
        repeat (7) tick();
        reset = 1'b1;
        tick();
        chk("rst_state", 32'(lane_state), 32'h0);
        chk("rst_rxstatus", 32'(rxstatus), 32'h0);
        chk("rst_phy", 32'(phystatus), 32'h0);
        chk("rst_idle", 32'(rxelecidle), 32'hF);
        chk("rst_sym", 32'({tx_sym, tx_symk, tx_valid}), 32'h0);
        chk("rst_link", 32'(linkup), 32'h0);
        reset = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
